// File: rtl/keypad_button_frontend.sv
// keypad_button_frontend: synchronises and debounces eight game buttons and a
// 3x4 keypad, and emits clean single-cycle press events for the game manager.
// Ports:
//   clk_2, rst_n            clock, async active-low reset
//   botton_1..botton_8      raw button levels (active-high, async)
//   KEY_COL[2:0], KEY_ROW   raw keypad column/row levels (active-high, async)
//   btn_level[7:0]          debounced button levels (bit i = botton_(i+1))
//   btn_pulse[7:0]          one-cycle pulse per debounced rising edge
//   key_valid, key_code     accepted keypad press strobe and its code
//   key_busy                keypad state machine is not idle
module keypad_button_frontend #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic       clk_2,
    input  logic       rst_n,
    input  logic       botton_1,
    input  logic       botton_2,
    input  logic       botton_3,
    input  logic       botton_4,
    input  logic       botton_5,
    input  logic       botton_6,
    input  logic       botton_7,
    input  logic       botton_8,
    input  logic [2:0] KEY_COL,
    input  logic [3:0] KEY_ROW,
    output logic [7:0] btn_level,
    output logic [7:0] btn_pulse,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CHECK, PRESSED, RELEASE} state_t;

    logic [14:0] raw, sync1, sync2;
    logic [7:0]  btn_s;
    logic [2:0]  col;
    logic [3:0]  row;

    assign raw = {KEY_ROW, KEY_COL, botton_8, botton_7, botton_6, botton_5,
                  botton_4, botton_3, botton_2, botton_1};

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign btn_s = sync2[7:0];
    assign col   = sync2[10:8];
    assign row   = sync2[14:11];

    // Buttons: per-bit stability counter; pulse is a registered rising edge
    // of the debounced level, so it lands one cycle after the level toggles.
    logic [CNT_W-1:0] btn_cnt [0:7];
    logic [7:0]       btn_prev;

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) btn_cnt[i] <= '0;
            btn_level <= '0;
            btn_prev  <= '0;
            btn_pulse <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (btn_s[i] != btn_level[i]) begin
                    if (btn_cnt[i] == LAST) begin
                        btn_level[i] <= ~btn_level[i];
                        btn_cnt[i]   <= '0;
                    end else begin
                        btn_cnt[i] <= btn_cnt[i] + 1'b1;
                    end
                end else begin
                    btn_cnt[i] <= '0;
                end
            end
            btn_prev  <= btn_level;
            btn_pulse <= btn_level & ~btn_prev;
        end
    end

    // Keypad sample classification and decode
    logic       col_one, row_one, single, any_high;
    logic [3:0] code;
    logic [3:0] row_base;
    logic [1:0] col_idx;

    assign col_one  = (col == 3'b001) || (col == 3'b010) || (col == 3'b100);
    assign row_one  = (row == 4'b0001) || (row == 4'b0010) ||
                      (row == 4'b0100) || (row == 4'b1000);
    assign single   = col_one && row_one;
    assign any_high = |{col, row};

    always_comb begin
        row_base = 4'd0;
        col_idx  = 2'd0;
        code     = 4'h0;
        case (row)
            4'b0001: row_base = 4'd1;
            4'b0010: row_base = 4'd4;
            4'b0100: row_base = 4'd7;
            default: row_base = 4'd0;
        endcase
        case (col)
            3'b010:  col_idx = 2'd1;
            3'b100:  col_idx = 2'd2;
            default: col_idx = 2'd0;
        endcase
        if (row[3]) begin
            // bottom row: * 0 #
            case (col_idx)
                2'd0:    code = 4'hA;
                2'd1:    code = 4'h0;
                default: code = 4'hB;
            endcase
        end else begin
            code = row_base + {2'b00, col_idx};
        end
    end

    // Keypad FSM
    state_t           state, state_n;
    logic [CNT_W-1:0] kcnt, kcnt_n;
    logic [3:0]       cand, cand_n, key_code_n;
    logic             key_valid_n;

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            kcnt      <= '0;
            cand      <= 4'h0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            kcnt      <= kcnt_n;
            cand      <= cand_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
        end
    end

    always_comb begin
        state_n     = state;
        kcnt_n      = kcnt;
        cand_n      = cand;
        key_code_n  = key_code;
        key_valid_n = 1'b0;
        case (state)
            IDLE: begin
                if (single) begin
                    cand_n  = code;
                    kcnt_n  = '0;
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (!single || code != cand) begin
                    state_n = IDLE;
                end else if (kcnt == LAST) begin
                    key_code_n  = cand;
                    key_valid_n = 1'b1;
                    state_n     = PRESSED;
                end else begin
                    kcnt_n = kcnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!any_high) begin
                    kcnt_n  = '0;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (any_high) begin
                    kcnt_n = '0;
                end else if (kcnt == LAST) begin
                    state_n = IDLE;
                end else begin
                    kcnt_n = kcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        key_busy = (state != IDLE);
    end

endmodule

// File: doc/keypad_button_frontend.md
# keypad_button_frontend

Input front end for the memory-pattern game, directly upstream of `GameManager`. It synchronises and debounces the eight play buttons (`botton_1`..`botton_8`) and the 3x4 keypad level inputs (`KEY_COL`, `KEY_ROW`). It emits clean single-cycle press events: a per-button pulse vector and a decoded keypad code with a valid strobe. `GameManager` consumes only these events and never sees raw pins.

## Interface
- `DEBOUNCE_CYCLES`, default 1000: number of consecutive stable clocks required before a change is accepted. Legal range is 2..65535.
- `CNT_W`, default 16: debounce counter width. It must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- `clk_2`  in  1  system clock, single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `botton_1`..`botton_8`  in  1 each  raw button levels, active-high, asynchronous to `clk_2`.
- `KEY_COL`  in  3  raw keypad column levels, active-high.
- `KEY_ROW`  in  4  raw keypad row levels, active-high.
- `btn_level`  out  8  debounced button levels. Bit i corresponds to `botton_(i+1)`.
- `btn_pulse`  out  8  one-cycle pulse on each debounced rising edge.
- `key_valid`  out  1  one-cycle strobe marking an accepted keypad press.
- `key_code`  out  4  code of the last accepted key. Holds its value between strobes.
- `key_busy`  out  1  high whenever the keypad FSM is not in IDLE.

## Operation
- All 15 raw inputs pass through a two-flop synchroniser before any other logic.
- **Buttons:** each bit has an independent counter and a debounced level.
  - When the synchronised input differs from `btn_level[i]`, the counter increments. When the input equals the level, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1, `btn_level[i]` toggles and the counter clears.
  - `btn_pulse[i]` is a registered pulse for the 0→1 transition of `btn_level[i]` only. Releases produce no pulse.
  - Several buttons may pulse in the same cycle.
- **Keypad decode:** a sample is "single" when exactly one `KEY_COL` bit and exactly one `KEY_ROW` bit are high.
  - Layout is row 0 = 1 2 3, row 1 = 4 5 6, row 2 = 7 8 9, row 3 = * 0 #, with col 0 on the left.
  - Codes: digits map to 4'h0..4'h9, * maps to 4'hA, # maps to 4'hB.
  - Any multi-bit or partial (one-side-only) sample is "invalid".
- **Keypad FSM:**
  - IDLE: on a single sample, latch the candidate code, clear the counter, go to CHECK.
  - CHECK: if the sample is not single, or its code differs from the candidate, return to IDLE. Otherwise increment the counter. When the counter reaches DEBOUNCE_CYCLES-1, load `key_code` with the candidate, pulse `key_valid`, and go to PRESSED.
  - PRESSED: stay while any `KEY_COL` or `KEY_ROW` bit is high. Extra keys or key changes are ignored. When all inputs are zero, clear the counter and go to RELEASE.
  - RELEASE: any high bit clears the counter and keeps the FSM in RELEASE. After DEBOUNCE_CYCLES consecutive all-zero samples, go to IDLE.
- Exactly one `key_valid` is produced per physical press. A key held indefinitely never repeats.

## Timing
- Reset values:
  - All synchroniser flops and counters are 0.
  - `btn_level`, `btn_pulse`, `key_valid`, and `key_busy` are 0.
  - `key_code` is 4'h0.
  - The FSM is in IDLE.
- Reset is asynchronous and takes effect mid-operation. A key or button still held when `rst_n` rises is treated as a new press and re-debounced from zero.
- Latency: take edge 0 as the first `clk_2` edge that samples a new stable raw level. Both `btn_pulse[i]` and `key_valid` are then high for exactly the cycle following edge 2+DEBOUNCE_CYCLES.
- `key_code` becomes valid in the same cycle as `key_valid` and is stable afterwards.
- Glitches shorter than DEBOUNCE_CYCLES clocks (after synchronisation) produce no output.
- No backpressure. The consumer must sample the events in the cycle they are asserted.

## Test plan
- **Reset:** assert `rst_n`=0 for 10 cycles with all inputs at 0. All outputs must be 0, and nothing may change for 5000 cycles after release.
- **Button debounce:** with DEBOUNCE_CYCLES=16, pulse `botton_5` high for 10 cycles. No `btn_pulse` is allowed. Then hold it high for 40 cycles. Expect `btn_pulse`=8'h10 for exactly one cycle, at edge 18 after the first sampling edge. `btn_level[4]` must stay 1 until 16 cycles after the release is synchronised.
- **Keypad decode:** drive `KEY_COL`[1] and `KEY_ROW`[0] for 50 cycles. Expect one `key_valid` with `key_code`=4'h2. Repeat with:
  - `KEY_COL`[1]+`KEY_ROW`[3] → 4'h0
  - `KEY_COL`[2]+`KEY_ROW`[3] → 4'hB
  - `KEY_COL`[0]+`KEY_ROW`[3] → 4'hA
- **Invalid sample:** drive `KEY_COL`=3'b011 with `KEY_ROW`=4'b0001. Expect no `key_valid`, and `key_busy` stays 0.
- **Hold and re-press:** hold key 5 for 200 cycles. Expect exactly one strobe. Add key 9 while key 5 is held: no strobe. Release all, then wait only 10 cycles before pressing 9 again: no strobe until RELEASE completes. After a full release, pressing 9 gives `key_code`=4'h9.
- **Mid-press reset:** pull `rst_n` low during CHECK. No strobe may occur. Re-press after reset gives a normal strobe.
